// File: rtl/vga_scanner.sv
// VGA raster generator for the Game-of-Life display: zoom/pan/wrap cell addressing,
// cell-RAM latency matching and RGB rendering with grid and cursor overlays.
module vga_scanner #(
    parameter int WIDTH      = 12,
    parameter int HSIZE      = 800,
    parameter int HFP        = 856,
    parameter int HSP        = 976,
    parameter int HMAX       = 1040,
    parameter int VSIZE      = 600,
    parameter int VFP        = 637,
    parameter int VSP        = 643,
    parameter int VMAX       = 666,
    parameter int HSPP       = 1,
    parameter int VSPP       = 1,
    parameter int P_PARAM_N  = 100,
    parameter int P_PARAM_M  = 75,
    parameter int SCROLL_MIN = 3,
    parameter int RD_LAT     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          shift_x,
    input  logic [15:0]          shift_y,
    input  logic [3:0]           scroll,
    input  logic [1:0]           color_mode,
    input  logic                 grid_en,
    input  logic                 setting_status,
    input  logic [2*WIDTH-1:0]   setting_pos,
    output logic [2*WIDTH-1:0]   rd_addr,
    output logic                 rd_en,
    input  logic                 vga_live,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 data_enable,
    output logic [7:0]           video_red,
    output logic [7:0]           video_green,
    output logic [7:0]           video_blue,
    output logic                 frame_start
);

    localparam int               AW     = 2 * WIDTH;
    localparam logic [WIDTH-1:0] H_LAST = WIDTH'(HMAX - 1);
    localparam logic [WIDTH-1:0] V_LAST = WIDTH'(VMAX - 1);
    localparam logic [3:0]       S_MIN  = 4'(SCROLL_MIN);
    localparam logic [3:0]       S_MAX  = 4'd7;
    localparam logic             HS_ON  = (HSPP != 0);
    localparam logic             VS_ON  = (VSPP != 0);

    typedef struct packed {
        logic          vis;
        logic          hs;
        logic          vs;
        logic          grid;
        logic          fs;
        logic [AW-1:0] addr;
    } pix_t;

    localparam pix_t PIX_IDLE = '{vis: 1'b0, hs: !HS_ON, vs: !VS_ON, grid: 1'b0, fs: 1'b0, addr: '0};

    logic [WIDTH-1:0] hdata, vdata;
    logic [15:0]      sx, sy;
    logic [3:0]       s;
    logic [1:0]       mode;
    logic             grid_on;
    logic             frame_end;

    assign frame_end = (hdata == H_LAST) && (vdata == V_LAST);

    // Raster counters; pan/zoom/colour settings are latched only on the last pixel of a frame.
    always_ff @(posedge clk) begin
        // NOTE: every clocked register here uses non-blocking assignment so all stages update from pre-edge values.
        if (rst) begin
            hdata   <= '0;
            vdata   <= '0;
            sx      <= '0;
            sy      <= '0;
            s       <= S_MIN;
            mode    <= 2'd0;
            grid_on <= 1'b0;
        end else begin
            if (hdata == H_LAST) begin
                hdata <= '0;
                vdata <= (vdata == V_LAST) ? '0 : vdata + 1'b1;
            end else begin
                hdata <= hdata + 1'b1;
            end
            if (frame_end) begin
                s       <= (scroll < S_MIN) ? S_MIN : ((scroll > S_MAX) ? S_MAX : scroll);
                sx      <= (shift_x >= 16'(P_PARAM_N)) ? 16'(P_PARAM_N - 1) : shift_x;
                sy      <= (shift_y >= 16'(P_PARAM_M)) ? 16'(P_PARAM_M - 1) : shift_y;
                mode    <= color_mode;
                grid_on <= grid_en;
            end
        end
    end

    logic [WIDTH-1:0] hcell, vcell, cell_mask;
    logic [16:0]      cx_sum, cy_sum, cx, cy;
    logic [31:0]      addr_full;
    logic             visible;
    pix_t             stage_d, stage_q;

    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latches are inferred.
        hcell     = hdata >> s;
        vcell     = vdata >> s;
        cx_sum    = 17'(hcell) + 17'(sx);
        cy_sum    = 17'(vcell) + 17'(sy);
        // Clamped pan keeps the sum below 2N (2M), so one conditional subtract wraps the torus.
        cx        = (cx_sum >= 17'(P_PARAM_N)) ? cx_sum - 17'(P_PARAM_N) : cx_sum;
        cy        = (cy_sum >= 17'(P_PARAM_M)) ? cy_sum - 17'(P_PARAM_M) : cy_sum;
        addr_full = 32'(cy) * 32'(P_PARAM_N) + 32'(cx);
        visible   = (hdata < WIDTH'(HSIZE)) && (vdata < WIDTH'(VSIZE));
        cell_mask = (WIDTH'(1) << s) - WIDTH'(1);

        stage_d      = PIX_IDLE;
        stage_d.vis  = visible;
        stage_d.hs   = ((hdata >= WIDTH'(HFP)) && (hdata < WIDTH'(HSP))) ~^ HS_ON;
        stage_d.vs   = ((vdata >= WIDTH'(VFP)) && (vdata < WIDTH'(VSP))) ~^ VS_ON;
        stage_d.grid = grid_on && (s >= 4'd3)
                       && (((hdata & cell_mask) == '0) || ((vdata & cell_mask) == '0));
        stage_d.fs   = (hdata == '0) && (vdata == '0);
        stage_d.addr = visible ? AW'(addr_full) : '0;
    end

    assign rd_addr = stage_q.addr;
    assign rd_en   = stage_q.vis;

    pix_t dly [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= PIX_IDLE;
            // NOTE: the delay line is a handful of flops, not a RAM, so it is cleared to keep stale syncs off the outputs.
            for (int i = 0; i < RD_LAT; i++) begin
                dly[i] <= PIX_IDLE;
            end
        end else begin
            stage_q <= stage_d;
            dly[0]  <= stage_q;
            for (int i = 1; i < RD_LAT; i++) begin
                dly[i] <= dly[i-1];
            end
        end
    end

    pix_t        tail;
    logic [7:0]  a;
    logic [23:0] rgb_d;

    assign tail = dly[RD_LAT-1];

    // Colour priority: blanking, cursor, live cell, grid line, dead cell.
    always_comb begin
        a     = tail.addr[7:0];
        rgb_d = 24'h000000;
        if (!tail.vis) begin
            rgb_d = 24'h000000;
        end else if (setting_status && (setting_pos == tail.addr)) begin
            rgb_d = vga_live ? 24'hFF0000 : 24'h0000FF;
        end else if (vga_live) begin
            case (mode)
                2'd0:    rgb_d = 24'hFFFFFF;
                2'd1:    rgb_d = {a[4:0], a[7:5], a[2:0], a[7:3], 8'hFF};
                2'd2:    rgb_d = 24'h00FF00;
                default: rgb_d = 24'h000000;
            endcase
        end else if (tail.grid) begin
            rgb_d = 24'h404040;
        end else if (mode == 2'd3) begin
            rgb_d = 24'hFFFFFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= !HS_ON;
            vsync       <= !VS_ON;
            data_enable <= 1'b0;
            video_red   <= 8'h00;
            video_green <= 8'h00;
            video_blue  <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            hsync       <= tail.hs;
            vsync       <= tail.vs;
            data_enable <= tail.vis;
            {video_red, video_green, video_blue} <= rgb_d;
            frame_start <= tail.fs;
        end
    end

endmodule
